// File: rtl/warp_fetch_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | warp_fetch_sched_pkg                                             |
// | Shared types and error bit positions for the warp fetch front end|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package warp_fetch_sched_pkg;

    localparam int ERR_INVALID_WARP_MASK = 0;
    localparam int ERR_INIT_ABORT        = 1;
    localparam int c_ERR_BITS            = 2;

    typedef enum logic [0:0] {
        FETCH_POL_RR    = 1'b0,
        FETCH_POL_FIXED = 1'b1
    } fetch_policy_e;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/warp_fetch_sched_rr_picker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_rr_picker                                                  |
// | Combinational one-of-N picker: rotating or lowest-index priority |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fetch_rr_picker
    import warp_fetch_sched_pkg::*;
#(
    parameter int NUM_WARPS = 32,
    parameter int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] req,
    input  logic [WID_W-1:0]     start,
    input  fetch_policy_e        policy,
    output logic [NUM_WARPS-1:0] grant,
    output logic [WID_W-1:0]     index,
    output logic                 any
);

    logic [WID_W:0] w_idx;
    logic           w_found;

    // One spare bit holds start+k so the wrap is a subtract, valid for any NUM_WARPS.
    always_comb begin
        grant   = '0;
        index   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            if (policy == FETCH_POL_FIXED) begin
                w_idx = (WID_W+1)'(k);
            end else begin
                w_idx = {1'b0, start} + (WID_W+1)'(k);
                if (w_idx >= (WID_W+1)'(NUM_WARPS)) begin
                    w_idx = w_idx - (WID_W+1)'(NUM_WARPS);
                end
            end
            if (!w_found && req[w_idx[WID_W-1:0]]) begin
                w_found = 1'b1;
                index   = w_idx[WID_W-1:0];
            end
        end
        if (w_found) begin
            grant[index] = 1'b1;
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/warp_fetch_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | warp_fetch_sched                                                 |
// | Turns an active-warp mask into a stream of (warp_id, pc) beats   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module warp_fetch_sched
    import warp_fetch_sched_pkg::*;
#(
    parameter int            NUM_WARPS = 32,
    parameter int            WID_W     = $clog2(NUM_WARPS),
    parameter int            PC_W      = 32,
    parameter fetch_policy_e POLICY    = FETCH_POL_RR
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       initialize,
    input  logic [PC_W*NUM_WARPS-1:0]  init_pc,
    input  logic [WID_W*NUM_WARPS-1:0] init_warp_id,
    input  logic [PC_W*NUM_WARPS-1:0]  next_pc,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [NUM_WARPS-1:0]       s_warp_mask,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic                       m_tlast,
    output logic [WID_W-1:0]           m_warp_id,
    output logic [WID_W-1:0]           m_slot,
    output logic [PC_W-1:0]            m_pc,
    output logic [31:0]                err,
    input  logic                       err_clear
);

    localparam logic [WID_W-1:0] c_LAST_SLOT = WID_W'(NUM_WARPS - 1);

    logic [PC_W-1:0]  w_init_pc  [NUM_WARPS];
    logic [PC_W-1:0]  w_next_pc  [NUM_WARPS];
    logic [WID_W-1:0] w_init_wid [NUM_WARPS];

    for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_unpack
        assign w_init_pc[gi]  = init_pc[gi*PC_W +: PC_W];
        assign w_next_pc[gi]  = next_pc[gi*PC_W +: PC_W];
        assign w_init_wid[gi] = init_warp_id[gi*WID_W +: WID_W];
    end

    fetch_state_e          r_state_q,     w_state_d;
    logic [NUM_WARPS-1:0]  r_mask_q,      w_mask_d;
    logic [WID_W-1:0]      r_last_idx_q,  w_last_idx_d;
    logic [PC_W-1:0]       r_pc_tbl_q  [NUM_WARPS];
    logic [PC_W-1:0]       w_pc_tbl_d  [NUM_WARPS];
    logic [WID_W-1:0]      r_wid_tbl_q [NUM_WARPS];
    logic [WID_W-1:0]      w_wid_tbl_d [NUM_WARPS];
    logic                  r_s_tready_q,  w_s_tready_d;
    logic                  r_m_tvalid_q,  w_m_tvalid_d;
    logic                  r_m_tlast_q,   w_m_tlast_d;
    logic [WID_W-1:0]      r_m_warp_id_q, w_m_warp_id_d;
    logic [WID_W-1:0]      r_m_slot_q,    w_m_slot_d;
    logic [PC_W-1:0]       r_m_pc_q,      w_m_pc_d;
    logic [c_ERR_BITS-1:0] r_err_q,       w_err_d;

    logic [WID_W-1:0]     w_start;
    logic [NUM_WARPS-1:0] w_pick_grant;
    logic [WID_W-1:0]     w_pick_index;
    logic                 w_pick_any;
    logic                 w_beat_acc;
    logic [NUM_WARPS-1:0] w_mask_left;

    assign w_start     = (r_last_idx_q == c_LAST_SLOT) ? '0 : r_last_idx_q + 1'b1;
    assign w_beat_acc  = r_m_tvalid_q & m_tready;
    assign w_mask_left = r_mask_q & ~w_pick_grant;

    fetch_rr_picker #(
        .NUM_WARPS (NUM_WARPS),
        .WID_W     (WID_W)
    ) u_picker (
        .req    (r_mask_q),
        .start  (w_start),
        .policy (POLICY),
        .grant  (w_pick_grant),
        .index  (w_pick_index),
        .any    (w_pick_any)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_mask_d      = r_mask_q;
        w_last_idx_d  = r_last_idx_q;
        w_pc_tbl_d    = r_pc_tbl_q;
        w_wid_tbl_d   = r_wid_tbl_q;
        w_s_tready_d  = r_s_tready_q;
        w_m_tvalid_d  = r_m_tvalid_q;
        w_m_tlast_d   = r_m_tlast_q;
        w_m_warp_id_d = r_m_warp_id_q;
        w_m_slot_d    = r_m_slot_q;
        w_m_pc_d      = r_m_pc_q;
        w_err_d       = err_clear ? '0 : r_err_q;

        case (r_state_q)
            IDLE: begin
                w_s_tready_d = 1'b1;
                if (s_tvalid && r_s_tready_q) begin
                    if (s_warp_mask == '0) begin
                        w_err_d[ERR_INVALID_WARP_MASK] = 1'b1;
                    end else begin
                        w_mask_d     = s_warp_mask;
                        w_state_d    = ISSUE;
                        w_s_tready_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                w_s_tready_d = 1'b0;
                if (w_beat_acc) begin
                    w_pc_tbl_d[r_m_slot_q] = w_next_pc[r_m_slot_q];
                end
                if (w_beat_acc && r_m_tlast_q) begin
                    w_state_d    = IDLE;
                    w_m_tvalid_d = 1'b0;
                    w_m_tlast_d  = 1'b0;
                    w_s_tready_d = 1'b1;
                end else if ((!r_m_tvalid_q || w_beat_acc) && w_pick_any) begin
                    w_m_tvalid_d  = 1'b1;
                    w_m_slot_d    = w_pick_index;
                    w_m_warp_id_d = r_wid_tbl_q[w_pick_index];
                    w_m_pc_d      = r_pc_tbl_q[w_pick_index];
                    w_m_tlast_d   = (w_mask_left == '0);
                    w_mask_d      = w_mask_left;
                    w_last_idx_d  = w_pick_index;
                end else if (w_beat_acc) begin
                    w_m_tvalid_d = 1'b0;
                end
            end
            default: w_state_d = IDLE;
        endcase

        // Table reload overrides any beat acceptance on the same edge.
        if (initialize) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                w_pc_tbl_d[i]  = w_init_pc[i];
                w_wid_tbl_d[i] = w_init_wid[i];
            end
            w_state_d    = IDLE;
            w_mask_d     = '0;
            w_m_tvalid_d = 1'b0;
            w_m_tlast_d  = 1'b0;
            w_s_tready_d = 1'b1;
            w_last_idx_d = c_LAST_SLOT;
            if (r_state_q == ISSUE) begin
                w_err_d[ERR_INIT_ABORT] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= IDLE;
            r_mask_q      <= '0;
            r_last_idx_q  <= c_LAST_SLOT;
            r_s_tready_q  <= 1'b0;
            r_m_tvalid_q  <= 1'b0;
            r_m_tlast_q   <= 1'b0;
            r_m_warp_id_q <= '0;
            r_m_slot_q    <= '0;
            r_m_pc_q      <= '0;
            r_err_q       <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                r_pc_tbl_q[i]  <= '0;
                r_wid_tbl_q[i] <= '0;
            end
        end else begin
            r_state_q     <= w_state_d;
            r_mask_q      <= w_mask_d;
            r_last_idx_q  <= w_last_idx_d;
            r_s_tready_q  <= w_s_tready_d;
            r_m_tvalid_q  <= w_m_tvalid_d;
            r_m_tlast_q   <= w_m_tlast_d;
            r_m_warp_id_q <= w_m_warp_id_d;
            r_m_slot_q    <= w_m_slot_d;
            r_m_pc_q      <= w_m_pc_d;
            r_err_q       <= w_err_d;
            r_pc_tbl_q    <= w_pc_tbl_d;
            r_wid_tbl_q   <= w_wid_tbl_d;
        end
    end

    assign s_tready  = r_s_tready_q;
    assign m_tvalid  = r_m_tvalid_q;
    assign m_tlast   = r_m_tlast_q;
    assign m_warp_id = r_m_warp_id_q;
    assign m_slot    = r_m_slot_q;
    assign m_pc      = r_m_pc_q;
    assign err       = {{(32-c_ERR_BITS){1'b0}}, r_err_q};

endmodule
`default_nettype wire
